// File: rtl/cordic_arbiter_if.sv
// Request/response and core-side signal bundle for the two-requester CORDIC arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface cordic_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [31:0] req0_data;
   logic [31:0] req1_data;
   logic        req0_ready;
   logic        req1_ready;
   logic        resp0_valid;
   logic        resp1_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        core_start;
   logic [31:0] core_dataa;
   logic [31:0] core_result;
   logic        core_done;
   logic        busy;

   modport slave (
      input  req0_valid, req1_valid, req0_data, req1_data, core_result, core_done,
      output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
             core_start, core_dataa, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_data, req1_data, core_result, core_done,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_err,
             core_start, core_dataa, busy
   );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC core between two FP32 requesters,
// with a bounded wait that answers with a quiet NaN and an error flag.
module cordic_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic            clock,
   input  logic            aclr,
   input  logic            clk_en,
   cordic_arbiter_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_reg, state_next;
   logic          ptr_reg, ptr_next;
   logic          grant_reg, grant_next;
   logic [31:0]   operand_reg, operand_next;
   logic [TW-1:0] timer_reg, timer_next;
   logic          err_reg, err_next;
   logic [31:0]   result_reg, result_next;

   logic          any_valid;
   logic          grant_sel;
   logic          accept;
   logic [1:0]    ready_vec;
   logic [1:0]    resp_vec;

   assign any_valid = bus.req0_valid | bus.req1_valid;
   // Pointer only matters under contention; a lone requester always wins.
   assign grant_sel = (bus.req0_valid && bus.req1_valid) ? ptr_reg : bus.req1_valid;
   assign accept    = clk_en && !aclr && (state_reg == IDLE) && any_valid;

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi] = accept && (grant_sel == 1'(gi));
      assign resp_vec[gi]  = clk_en && !aclr && (state_reg == RESP) && (grant_reg == 1'(gi));
   end

   assign bus.req0_ready  = ready_vec[0];
   assign bus.req1_ready  = ready_vec[1];
   assign bus.resp0_valid = resp_vec[0];
   assign bus.resp1_valid = resp_vec[1];
   assign bus.resp_data   = result_reg;
   assign bus.resp_err    = err_reg;
   assign bus.core_start  = !aclr && (state_reg == ISSUE);
   assign bus.core_dataa  = operand_reg;
   assign bus.busy        = !aclr && (state_reg != IDLE);

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      grant_next   = grant_reg;
      operand_next = operand_reg;
      timer_next   = timer_reg;
      err_next     = err_reg;
      result_next  = result_reg;
      case (state_reg)
         IDLE: begin
            if (any_valid) begin
               grant_next   = grant_sel;
               ptr_next     = ~grant_sel;
               operand_next = grant_sel ? bus.req1_data : bus.req0_data;
               state_next   = ISSUE;
            end
         end
         ISSUE: begin
            timer_next = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // A done arriving on the last allowed cycle still counts as success.
            if (bus.core_done) begin
               result_next = bus.core_result;
               err_next    = 1'b0;
               state_next  = RESP;
            end else if (timer_reg == TW'(TIMEOUT - 1)) begin
               result_next = QNAN;
               err_next    = 1'b1;
               state_next  = RESP;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (aclr) begin
         state_reg   <= IDLE;
         ptr_reg     <= 1'b0;
         grant_reg   <= 1'b0;
         operand_reg <= '0;
         timer_reg   <= '0;
         err_reg     <= 1'b0;
         result_reg  <= '0;
      end else if (clk_en) begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         grant_reg   <= grant_next;
         operand_reg <= operand_next;
         timer_reg   <= timer_next;
         err_reg     <= err_next;
         result_reg  <= result_next;
      end
   end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench: behavioural CORDIC core plus transaction-level reference
// (round-robin pointer, fixed latencies, timeout value) for cordic_arbiter.
module tb_cordic_arbiter;
   localparam int TIMEOUT = 15;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic clock = 1'b0;
   logic aclr = 1'b1;
   logic clk_en = 1'b1;

   cordic_arbiter_if bus ();

   cordic_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .aclr  (aclr),
      .clk_en(clk_en),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   bit ptr_model = 1'b0;

   // Core model: result fixed at start, done level appears 5 enabled edges later and persists.
   int          core_cnt = 0;
   logic [31:0] core_res = '0;
   bit          core_hang = 1'b0;
   bit          core_force = 1'b0;

   function automatic logic [31:0] core_fn(input logic [31:0] a);
      return (a == 32'h3F80_0000) ? 32'h3F0A_5140 : ({a[15:0], a[31:16]} ^ 32'h1357_9BDF);
   endfunction

   always @(posedge clock) begin
      if (aclr) core_cnt <= 0;
      else if (clk_en) begin
         if (bus.core_start) begin
            core_cnt <= 5;
            core_res <= core_fn(bus.core_dataa);
         end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   assign bus.core_done   = !core_hang && (core_force || core_cnt == 1);
   assign bus.core_result = core_res;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full request/response; the DUT must be IDLE on entry.
   task automatic txn(input bit v0, input bit v1, input logic [31:0] d0, input logic [31:0] d1,
                      input bit hang, input bit stale, input int gap_len);
      bit          got;
      bit          exp_g;
      int          lat;
      int          exp_lat;
      logic [31:0] exp_data;
      logic [31:0] held;
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      bus.req0_data  = d0;
      bus.req1_data  = d1;
      core_hang      = hang;
      #1;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
         if (bus.req0_ready || bus.req1_ready) got = 1'b1;
         else tick();
      end
      exp_g    = (v0 && v1) ? ptr_model : v1;
      exp_data = exp_g ? d1 : d0;
      ptr_model = !exp_g;
      chk("grant_seen", 32'(got), 32'd1);
      chk("grant_id", 32'({bus.req1_ready, bus.req0_ready}), exp_g ? 32'd2 : 32'd1);

      tick();
      if (exp_g) bus.req1_valid = 1'b0;
      else bus.req0_valid = 1'b0;
      core_force = stale;
      #1;
      chk("core_start", 32'(bus.core_start), 32'd1);
      chk("core_dataa", bus.core_dataa, exp_data);
      chk("ready_issue", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);

      got = 1'b0;
      lat = 0;
      for (int k = 2; k < 60 && !got; k++) begin
         tick();
         core_force = 1'b0;
         clk_en = !(gap_len > 0 && k >= 3 && k < 3 + gap_len);
         #1;
         if (!clk_en)
            chk("gated_strobes", 32'({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid}), 32'd0);
         else if (bus.resp0_valid || bus.resp1_valid) begin
            got = 1'b1;
            lat = k;
         end else if (k > 2 && bus.core_start) begin
            chk("start_once", 32'(bus.core_start), 32'd0);
         end
      end
      exp_lat = (hang ? TIMEOUT + 2 : 7) + gap_len;
      chk("resp_seen", 32'(got), 32'd1);
      chk("resp_latency", 32'(lat), 32'(exp_lat));
      chk("resp_port", 32'({bus.resp1_valid, bus.resp0_valid}), exp_g ? 32'd2 : 32'd1);
      chk("resp_data", bus.resp_data, hang ? QNAN : core_fn(exp_data));
      chk("resp_err", 32'(bus.resp_err), 32'(hang));
      held = bus.resp_data;
      $display("txn: v=%b%b grant=%0d data=%h result=%h err=%0d latency=%0d",
               v1, v0, exp_g, exp_data, bus.resp_data, bus.resp_err, lat);

      tick();
      core_hang = 1'b0;
      #1;
      chk("idle_after_resp", 32'({bus.busy, bus.resp0_valid, bus.resp1_valid}), 32'd0);
      chk("resp_data_held", bus.resp_data, held);
   endtask

   initial begin
      logic resp_any;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_data  = 32'hDEAD_BEEF;
      bus.req1_data  = 32'hCAFE_F00D;

      // Reset with both requesters pushing: nothing may be accepted.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_outputs", 32'({bus.req0_ready, bus.req1_ready, bus.resp0_valid,
                                   bus.resp1_valid, bus.core_start, bus.busy}), 32'd0);
      end
      chk("reset_resp_data", bus.resp_data, 32'd0);
      chk("reset_resp_err", 32'(bus.resp_err), 32'd0);
      chk("reset_core_dataa", bus.core_dataa, 32'd0);
      aclr = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      $display("reset: released");

      // Contention: grants alternate starting from requester 0.
      for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 0);

      // Known-value single request.
      txn(1'b1, 1'b0, 32'h3F80_0000, 32'h0, 1'b0, 1'b0, 0);

      // Timeout, then a normal request.
      txn(1'b1, 1'b0, $urandom, $urandom, 1'b1, 1'b0, 0);
      txn(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 0);

      // Enable gap in WAIT and stale done in ISSUE.
      txn(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 3);
      txn(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b1, 0);

      // Reset mid-operation: no response, pointer back to 0.
      bus.req0_valid = 1'b1;
      bus.req0_data  = $urandom;
      bus.req1_valid = 1'b0;
      #1;
      chk("abort_grant", 32'(bus.req0_ready), 32'd1);
      tick();
      bus.req0_valid = 1'b0;
      tick();
      tick();
      chk("abort_in_wait", 32'(bus.busy), 32'd1);
      aclr = 1'b1;
      #1;
      chk("abort_busy_gated", 32'(bus.busy), 32'd0);
      tick();
      aclr = 1'b0;
      #1;
      chk("abort_idle", 32'({bus.busy, bus.core_start}), 32'd0);
      resp_any = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         resp_any = resp_any | bus.resp0_valid | bus.resp1_valid | bus.busy;
      end
      chk("abort_no_resp", 32'(resp_any), 32'd0);
      $display("abort: reset in WAIT, no response");
      ptr_model = 1'b0;
      txn(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 0);
      txn(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 0);

      // Randomised mix.
      for (int i = 0; i < 20; i++) begin
         int pat;
         pat = int'($urandom_range(1, 3));
         txn(pat[0], pat[1], $urandom, $urandom, ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max WAIT-state cycles (clk_en-qualified) before abandoning a core operation.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port aclr  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port clk_en  in  1  global enable; low freezes all state.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester 0/1 has an FP32 operand pending.
REQ-006 SHALL have ports req0_data / req1_data  in  32  FP32 angle operand.
REQ-007 SHALL have ports req0_ready / req1_ready  out  1  operand accepted this cycle.
REQ-008 SHALL have ports resp0_valid / resp1_valid  out  1  one-cycle result strobe to requester 0/1.
REQ-009 SHALL have port resp_data  out  32  FP32 result, shared, qualified by respN_valid.
REQ-010 SHALL have port resp_err  out  1  result produced by timeout, qualified by respN_valid.
REQ-011 SHALL have ports core_start out 1, core_dataa out 32: drive the shared CORDIC core.
REQ-012 SHALL have ports core_result in 32, core_done in 1: from the CORDIC core; done is a level that is true while the core's iteration index equals final.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; transitions only on clk_en-high edges.
REQ-015 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally (only if clk_en high), latch data and grant id, go ISSUE.
REQ-016 Arbitration SHALL be round-robin: pointer selects preferred requester; on both valid, preferred wins; after any grant pointer moves to the other requester; single valid is granted regardless of pointer.
REQ-017 The non-granted requester's ready SHALL be low; at most one ready high per cycle; ready SHALL be low outside IDLE.
REQ-018 ISSUE: core_start SHALL be 1 and core_dataa SHALL equal latched operand for exactly one clk_en cycle; WAIT timer cleared; go WAIT.
REQ-019 core_start SHALL be 0 in all other states; core_dataa SHALL hold the latched operand in all states.
REQ-020 WAIT: core_done SHALL be sampled only in WAIT (stale done during ISSUE ignored); on core_done latch core_result into resp_data, clear err, go RESP.
REQ-021 WAIT: if core_done low and timer == TIMEOUT-1, SHALL load resp_data = 32'h7FC00000, set err, go RESP; else timer increments (width ceil(log2(TIMEOUT))+1, no wrap).
REQ-022 core_done and timeout in the same cycle: done SHALL win (err=0).
REQ-023 RESP: respN_valid SHALL be high for the latched grant id only, for one clk_en cycle; resp_err reflects err; next state IDLE.
REQ-024 No new grant SHALL occur in the RESP cycle; earliest next ready is the following IDLE cycle.
REQ-025 With the 4-iteration unrolled core (done 5 edges after start), accept in cycle C0 SHALL yield core_start in C1, done in C6, respN_valid in C7.
REQ-026 clk_en low SHALL freeze state, pointer, timer and latches; reqN_ready and respN_valid SHALL be forced low; core_start holds its value.
REQ-027 resp_data and resp_err SHALL hold last values until next RESP load.

Reset
REQ-028 aclr high on an edge SHALL override clk_en: state=IDLE, pointer=0, timer=0, err=0, resp_data=0, latched operand=0, grant id=0.
REQ-029 During and after reset: core_start=0, all ready=0, all respN_valid=0, busy=0.
REQ-030 aclr mid-operation SHALL discard the in-flight request with no response; requester must re-present.

Verification
REQ-031 Single request: req0 data 32'h3F800000 at C0, core model done at C6 with result 32'h3F0A5140 -> req0_ready C0, core_start C1 with dataa 32'h3F800000, resp0_valid C7, resp_data 32'h3F0A5140, resp_err 0.
REQ-032 Contention: req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1; each resp to correct port; ready never concurrent.
REQ-033 Timeout: core_done held 0 -> resp0_valid 1 cycle after TIMEOUT WAIT cycles, resp_data 32'h7FC00000, resp_err 1; next request serviced normally.
REQ-034 clk_en low 3 cycles during WAIT -> latency stretched by exactly 3 cycles; no ready/resp strobes while low.
REQ-035 aclr asserted in WAIT -> IDLE next cycle, no resp strobe, busy 0, pointer 0; subsequent req1 granted.
REQ-036 core_done high during ISSUE cycle (stale) -> ignored; response uses done observed in WAIT.
